// File: rtl/ddr_lane_if.sv
// Bundles the game-side controls and display-side results of the note-lane engine.
// The master drives tick/spawn/inject/key; the slave (the engine) returns grid/score/combo/pulses.
interface ddr_lane_if #(
  parameter int LANES        = 4,
  parameter int DEPTH        = 8,
  parameter int SCORE_DIGITS = 4
);
  logic                      tick;
  logic                      spawn_en;
  logic [LANES-1:0]          inject;
  logic [LANES-1:0]          key;
  logic [LANES*DEPTH-1:0]    grid;
  logic [SCORE_DIGITS*4-1:0] score;
  logic [7:0]                combo;
  logic                      hit_pulse;
  logic                      miss_pulse;

  modport master (
    output tick, spawn_en, inject, key,
    input  grid, score, combo, hit_pulse, miss_pulse
  );

  modport slave (
    input  tick, spawn_en, inject, key,
    output grid, score, combo, hit_pulse, miss_pulse
  );
endinterface

// File: rtl/ddr_lane_engine.sv
// Note-lane engine: falling-note shift registers, hit-window judging, BCD score and combo.
// Define SCORE_PENALTY_EN to make misses subtract from the score (saturating at zero).
module ddr_lane_engine #(
  parameter int LANES        = 4,
  parameter int DEPTH        = 8,
  parameter int HIT_ROWS     = 2,
  parameter int LFSR_W       = 10,
  parameter int LFSR_SEED    = 1,
  parameter int SCORE_DIGITS = 4
) (
  input logic       clk,
  input logic       reset,
  ddr_lane_if.slave bus
);

  localparam int GW = LANES * DEPTH;
  localparam int SW = SCORE_DIGITS * 4;

  // Maximal-length Fibonacci feedback taps, bit i set means LFSR bit i feeds the XOR
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      32'd4:   tap_mask = 32'h0000_000C;
      32'd5:   tap_mask = 32'h0000_0014;
      32'd6:   tap_mask = 32'h0000_0030;
      32'd7:   tap_mask = 32'h0000_0060;
      32'd8:   tap_mask = 32'h0000_00B8;
      32'd9:   tap_mask = 32'h0000_0110;
      32'd10:  tap_mask = 32'h0000_0240;
      32'd11:  tap_mask = 32'h0000_0500;
      32'd12:  tap_mask = 32'h0000_0829;
      32'd13:  tap_mask = 32'h0000_100D;
      32'd14:  tap_mask = 32'h0000_2015;
      32'd15:  tap_mask = 32'h0000_6000;
      32'd16:  tap_mask = 32'h0000_D008;
      default: tap_mask = 32'h0001_2000;
    endcase
  endfunction

  localparam logic [31:0]       TAPS_ALL = tap_mask(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];

  function automatic logic [4:0] popcnt(input logic [LANES-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < LANES; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction

  function automatic logic [SW-1:0] bcd_add(input logic [SW-1:0] s, input logic [4:0] amt);
    logic [3:0]    d0, d1, ad;
    logic [4:0]    a;
    logic          c;
    logic [SW-1:0] r;
    d0 = 4'(amt % 5'd10);
    d1 = 4'(amt / 5'd10);
    c  = 1'b0;
    r  = s;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      ad = (i == 0) ? d0 : ((i == 1) ? d1 : 4'd0);
      a  = {1'b0, s[i*4 +: 4]} + {1'b0, ad} + {4'd0, c};
      if (a > 5'd9) begin
        a = a - 5'd10;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[i*4 +: 4] = a[3:0];
    end
    if (c || (SCORE_DIGITS < 2 && d1 != 4'd0)) r = {SCORE_DIGITS{4'h9}};
    return r;
  endfunction

`ifdef SCORE_PENALTY_EN
  function automatic logic [SW-1:0] bcd_sub(input logic [SW-1:0] s, input logic [4:0] amt);
    logic [3:0]    d0, d1, sd;
    logic [4:0]    a;
    logic          b;
    logic [SW-1:0] r;
    d0 = 4'(amt % 5'd10);
    d1 = 4'(amt / 5'd10);
    b  = 1'b0;
    r  = s;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      sd = (i == 0) ? d0 : ((i == 1) ? d1 : 4'd0);
      a  = {1'b0, s[i*4 +: 4]} - {1'b0, sd} - {4'd0, b};
      if (a[4]) begin
        a = a + 5'd10;
        b = 1'b1;
      end else begin
        b = 1'b0;
      end
      r[i*4 +: 4] = a[3:0];
    end
    if (b || (SCORE_DIGITS < 2 && d1 != 4'd0)) r = '0;
    return r;
  endfunction
`endif

  logic [GW-1:0]     grid_r, clr_s, kept_s, grid_next_s;
  logic [SW-1:0]     score_r, score_next_s;
  logic [7:0]        combo_r, combo_next_s;
  logic              hit_r, miss_r;
  logic [LFSR_W-1:0] lfsr_r, lfsr_next_s;
  logic [LANES-1:0]  key_q_r, press_s, hit_s, bad_s, exit_s, spawn_s, row0_s;
  logic [4:0]        h_s, m_s;

  // Judge presses: each press clears the lowest note inside the hit window or is a bad press
  always_comb begin
    press_s = bus.key & ~key_q_r;
    clr_s   = '0;
    hit_s   = '0;
    bad_s   = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int r = DEPTH - 1; r >= DEPTH - HIT_ROWS; r--) begin
        if (press_s[l] && grid_r[l*DEPTH + r] && !hit_s[l]) begin
          clr_s[l*DEPTH + r] = 1'b1;
          hit_s[l]           = 1'b1;
        end else begin
          clr_s[l*DEPTH + r] = 1'b0;
        end
      end
      bad_s[l] = press_s[l] & ~hit_s[l];
    end
  end

  // Advance lanes on tick; the cleared grid is shifted so a hit note never counts as a miss
  always_comb begin
    logic [DEPTH-1:0] lane_v;
    lane_v      = '0;
    kept_s      = grid_r & ~clr_s;
    lfsr_next_s = {lfsr_r[LFSR_W-2:0], ^(lfsr_r & TAPS)};
    grid_next_s = kept_s;
    for (int l = 0; l < LANES; l++) begin
      spawn_s[l] = bus.spawn_en && lfsr_r[LFSR_W-1] &&
                   ((32'(lfsr_r[LFSR_W-2:0]) % LANES) == l);
      row0_s[l]  = bus.inject[l] | spawn_s[l];
      exit_s[l]  = bus.tick & kept_s[l*DEPTH + DEPTH - 1];
      lane_v     = kept_s[l*DEPTH +: DEPTH];
      if (bus.tick) begin
        grid_next_s[l*DEPTH +: DEPTH] = (lane_v << 1) | DEPTH'(row0_s[l]);
      end else begin
        grid_next_s[l*DEPTH +: DEPTH] = lane_v;
      end
    end
  end

  // Per-cycle hit/miss totals drive score and combo
  always_comb begin
    logic [8:0] sum;
    h_s = popcnt(hit_s);
    m_s = popcnt(bad_s) + popcnt(exit_s);
    sum = {1'b0, combo_r} + {4'd0, h_s};
`ifdef SCORE_PENALTY_EN
    if (h_s >= m_s) begin
      score_next_s = bcd_add(score_r, h_s - m_s);
    end else begin
      score_next_s = bcd_sub(score_r, m_s - h_s);
    end
`else
    score_next_s = bcd_add(score_r, h_s);
`endif
    if (m_s != 5'd0) begin
      combo_next_s = 8'd0;
    end else if (sum > 9'd255) begin
      combo_next_s = 8'd255;
    end else begin
      combo_next_s = sum[7:0];
    end
  end

  // State registers; reset wins over tick and key
  always_ff @(posedge clk) begin
    if (!reset) begin
      grid_r  <= '0;
      score_r <= '0;
      combo_r <= 8'd0;
      hit_r   <= 1'b0;
      miss_r  <= 1'b0;
      lfsr_r  <= LFSR_W'(LFSR_SEED);
      key_q_r <= '0;
    end else begin
      grid_r  <= grid_next_s;
      score_r <= score_next_s;
      combo_r <= combo_next_s;
      hit_r   <= (h_s != 5'd0);
      miss_r  <= (m_s != 5'd0);
      key_q_r <= bus.key;
      if (bus.tick) begin
        lfsr_r <= lfsr_next_s;
      end else begin
        lfsr_r <= lfsr_r;
      end
    end
  end

  assign bus.grid       = grid_r;
  assign bus.score      = score_r;
  assign bus.combo      = combo_r;
  assign bus.hit_pulse  = hit_r;
  assign bus.miss_pulse = miss_r;

endmodule

// File: doc/ddr_lane_engine.md
Name: ddr_lane_engine

Overview:
- Parametrised note-lane engine for the dance game: LANES columns, each a DEPTH-deep shift register of falling notes, replacing the fixed 4x8 hand-instantiated light chains.
- Adds hit-window judging, miss detection, BCD score with saturation, combo counter and a chart-injection port.
- Sits between the clock divider / input conditioning and the LED array scanner and score display decoders.

Parameters:
- LANES, 4, number of note columns (1..9)
- DEPTH, 8, rows per lane; row 0 = top (spawn), row DEPTH-1 = bottom
- HIT_ROWS, 2, bottom rows forming the hit window (1..DEPTH)
- LFSR_W, 10, random generator width (>=4)
- LFSR_SEED, 1, nonzero reset value of the LFSR
- SCORE_DIGITS, 4, BCD score digits

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low; reset==0 at a rising clk edge clears all state
- tick  in  1  one-cycle step enable; notes advance one row per tick
- spawn_en  in  1  enables random note generation
- inject  in  LANES  forced notes written into row 0 on the next tick
- key  in  LANES  button levels, active-high, already debounced
- grid  out  LANES*DEPTH  note map; bit l*DEPTH+r = lane l, row r
- score  out  SCORE_DIGITS*4  BCD score; digit 0 in bits [3:0]
- combo  out  8  consecutive-hit count, saturating at 255
- hit_pulse  out  1  high one cycle when >=1 hit occurred
- miss_pulse  out  1  high one cycle when >=1 miss occurred

Behaviour:
- Reset (reset==0 at clk edge): grid=0, score=all zeros, combo=0, hit_pulse=0, miss_pulse=0, LFSR=LFSR_SEED, key_q=0.
- Key edge: key_q registers key every cycle; press[l] = key[l] & ~key_q[l]. Holding a key produces one press only.
- LFSR: Fibonacci, maximal-length taps for LFSR_W, advances every tick (not every cycle); never all-zero.
- Spawn: on tick, spawn lane = LFSR[LFSR_W-2:0] mod LANES; spawn only when spawn_en=1 and LFSR[LFSR_W-1]=1. At most one random note per tick. New row 0 = inject | random spawn vector.
- Judging, evaluated on the pre-edge grid, per lane l with press[l]=1:
  - note in any row DEPTH-HIT_ROWS..DEPTH-1: clear the lowest such note (largest row index); counts as a hit.
  - no note in the window: bad press, counts as a miss; grid unchanged.
- Advance on tick: every lane shifts row r -> r+1 after judging clears are applied. A note leaving row DEPTH-1 counts as a miss. A note cleared by a hit in the same cycle is not counted as a miss.
- Per-cycle totals: hits H (0..LANES) and misses M (0..2*LANES).
- Score: BCD add H, carry ripples across digits; saturates at all nines (e.g. 9999). Updated on the same edge as grid.
- Combo: if M>0, combo=0 (any hits that cycle are discarded); else combo=min(combo+H, 255).
- hit_pulse=(H>0) and miss_pulse=(M>0), registered; both valid in the cycle after the judging edge.
- Latency: press or tick to grid/score/combo update = 1 edge after the key edge is seen.
- reset low mid-operation: overrides tick and key on that edge; no pulses are emitted.

Optional Feature:
- Macro SCORE_PENALTY_EN.
- Defined: each cycle with M>0 subtracts M from score in BCD, saturating at 0 (0000). When H and M are both nonzero, the net H-M is applied with saturation at both ends.
- Undefined: misses affect only combo and miss_pulse; score never decreases.

Test Plan:
- Reset with tick=1, key=all ones -> grid=0, score=0000, combo=0, pulses 0; after release, held keys produce no press.
- spawn_en=0, inject=0001 for one tick, then 7 more ticks -> bit 7 set (lane 0, row 7); the 9th tick clears it and gives miss_pulse=1, combo=0, score=0000 (with or without the penalty macro).
- Note at lane 2 row 6, key[2] 0->1 -> bit 22 cleared, hit_pulse=1, score=0001, combo=1; holding key[2] for 5 more cycles -> no change.
- combo=3, press lane 1 with an empty window -> miss_pulse=1, combo=0; score 0003 -> 0002 only with SCORE_PENALTY_EN.
- score=0099, simultaneous hits in lanes 0 and 3 -> score=0101, combo+2; score=9998 with 2 hits -> 9999.
- Note at row 7 with press and tick on the same edge -> hit counted, no miss_pulse, note gone; spawn_en=1 for 1023 ticks with LFSR_W=10 -> LFSR never 0 and the sequence repeats with period 1023.
